// File: rtl/seg7_scan_driver.sv
// Basys3 4-digit 7-segment scan driver: binary -> BCD (double dabble), frame-aligned commit, refresh scan.
// Latency: BCD conversion takes 14 cycles; a new value appears at the next frame boundary (idx 3->0).
// Backpressure: none; value_valid while busy is dropped, and the latest finished result overwrites pending.
// Ports: clk/rst (sync, active-high); value[13:0]+value_valid input strobe; busy = conversion running;
//        overflow = committed content is out of range; an_sel[3:0] active-low anodes; seg[6:0] active-low gfedcba.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        value_valid,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  an_sel,
  output logic [6:0]  seg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [29:0] sr_q, sr_d;        // {bcd[15:0], bin[13:0]}
  logic [29:0] sr_adj, sr_shift;
  logic [3:0]  shcnt_q, shcnt_d;
  logic [15:0] pend_bcd_q, pend_bcd_d;
  logic        pend_ovf_q, pend_ovf_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] disp_bcd_q, disp_bcd_d;
  logic        disp_ovf_q, disp_ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        tick, commit;
  logic        res_vld, res_ovf;
  logic [15:0] res_bcd;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [15:0] bcd, input logic ovf,
                                           input logic [1:0] k);
    logic blank;
    blank = 1'b0;
    if (BLANK_LZ) begin
      case (k)
        2'd1:    blank = (bcd[15:4]  == 12'd0);
        2'd2:    blank = (bcd[15:8]  == 8'd0);
        2'd3:    blank = (bcd[15:12] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
    if (ovf)        return 7'b0111111;
    else if (blank) return 7'b1111111;
    else            return decode(bcd[{k, 2'b00} +: 4]);
  endfunction

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[14 + 4*i +: 4] >= 4'd5) begin
        sr_adj[14 + 4*i +: 4] = sr_q[14 + 4*i +: 4] + 4'd3;
      end
    end
  end

  assign sr_shift = {sr_adj[28:0], 1'b0};

  // Conversion FSM; res_* is the one-cycle "new pending content" event.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    shcnt_d = shcnt_q;
    res_vld = 1'b0;
    res_ovf = 1'b0;
    res_bcd = 16'd0;
    case (state_q)
      IDLE: begin
        if (value_valid) begin
          if (value <= 14'd9999) begin
            sr_d    = {16'd0, value};
            shcnt_d = 4'd14;
            state_d = SHIFT;
          end else begin
            res_vld = 1'b1;
            res_ovf = 1'b1;
          end
        end
      end
      SHIFT: begin
        sr_d    = sr_shift;
        shcnt_d = shcnt_q - 4'd1;
        if (shcnt_q == 4'd1) begin
          res_vld = 1'b1;
          res_bcd = sr_shift[29:14];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan, commit and output registers. Commit reads the old pending value, so a
  // result finishing on the commit edge lands in pending for the next frame.
  always_comb begin
    tick   = (cnt_q == CW'(REFRESH_DIV - 1));
    commit = tick && (idx_q == 2'd3) && pend_vld_q;

    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    disp_bcd_d = commit ? pend_bcd_q : disp_bcd_q;
    disp_ovf_d = commit ? pend_ovf_q : disp_ovf_q;

    pend_bcd_d = pend_bcd_q;
    pend_ovf_d = pend_ovf_q;
    pend_vld_d = pend_vld_q;
    if (res_vld) begin
      pend_bcd_d = res_bcd;
      pend_ovf_d = res_ovf;
      pend_vld_d = 1'b1;
    end else if (commit) begin
      pend_vld_d = 1'b0;
    end

    // Outputs follow next-state index/data so the new digit lights on the tick edge itself.
    an_d  = ~(4'b0001 << idx_d);
    seg_d = digit_seg(disp_bcd_d, disp_ovf_d, idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      shcnt_q    <= '0;
      pend_bcd_q <= '0;
      pend_ovf_q <= 1'b0;
      pend_vld_q <= 1'b0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1110;
      seg_q      <= 7'b1000000;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      shcnt_q    <= shcnt_d;
      pend_bcd_q <= pend_bcd_d;
      pend_ovf_q <= pend_ovf_d;
      pend_vld_q <= pend_vld_d;
      disp_bcd_q <= disp_bcd_d;
      disp_ovf_q <= disp_ovf_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign overflow = disp_ovf_q;
  assign an_sel   = an_q;
  assign seg      = seg_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives the Basys3 4-digit multiplexed 7-segment display directly; owns anode rotation and segment decoding.
- Accepts a 14-bit binary value (the servo/SPI steering value to show) with a valid strobe.
- Converts the value to BCD with a sequential double-dabble FSM, then commits it to the display only at a frame boundary, so a frame never shows a mix of old and new digits.
- Handles refresh prescaling, leading-zero blanking and overflow indication.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays lit (1 kHz per digit at 100 MHz); minimum 2.
- BLANK_LZ, 1, 1 = blank leading zeros on digits 3..1; 0 = show every digit.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- value  input  14  binary value to display, valid range 0..9999
- value_valid  input  1  single-cycle strobe; value is sampled when high
- busy  output  1  high while a BCD conversion is running
- overflow  output  1  high while the committed display content is an out-of-range value
- an_sel  output  4  anode select, active-low, one-hot-low; bit 0 is the rightmost digit
- seg  output  7  segment cathodes, active-low; seg[0]=a … seg[6]=g

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: an_sel=4'b1110; seg=7'b1000000 ("0"); busy=0; overflow=0. The display register holds BCD 0000 and is not overflowed, the pending flag is clear, the prescaler is 0 and the digit index is 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick=1 when the count equals REFRESH_DIV-1.
- Digit index: on a tick edge, idx <= (idx+1) mod 4. an_sel and seg are registered and update on the same edge, so each digit is lit for exactly REFRESH_DIV cycles.
- Anode mapping: idx 0→1110, 1→1101, 2→1011, 3→0111.
- Conversion FSM states: IDLE, SHIFT.
- IDLE:
  - If value_valid=1 and value≤9999: capture the value, clear the BCD scratch, set the shift count to 14, go to SHIFT, busy=1 from the next cycle.
  - If value_valid=1 and value>9999: load the pending register with ovf=1 in one cycle, set the pending flag, stay in IDLE, busy stays 0.
- SHIFT: each cycle, add 3 to any BCD nibble ≥5, then shift the {bcd, bin} register left by 1. After the 14th shift, write the result to the pending register with ovf=0, set the pending flag and return to IDLE.
  - busy is high for exactly 14 cycles.
- value_valid while busy=1: ignored and dropped, no queuing.
- Commit rule: on a tick edge where idx goes 3→0 with the pending flag set, the display register (4 BCD nibbles plus ovf) is loaded from pending and the flag is cleared. The digit shown after that edge (idx 0) already uses the new data.
- Pending overwrite: if a second conversion completes before commit, pending is overwritten and the latest value wins.
- Simultaneous events:
  - Conversion completing on the same edge as a commit: the commit takes the old pending value; the new result sets pending for the next frame.
  - Overflow capture on a commit edge: handled the same way.
- overflow output: equals the committed display ovf bit, so it changes only at a frame boundary.
- Segment decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Overflow display: every digit shows a dash, 7'b0111111.
- Blanking (BLANK_LZ=1, no overflow): digit k∈{3,2,1} shows 7'b1111111 when nibble k and all higher nibbles are 0. Digit 0 is never blanked. The anode is still driven while a digit is blanked.
- Reset mid-conversion or with pending set: the conversion is aborted, busy=0, pending is dropped, and the display returns to the reset values on the next cycle.

Test Plan (bench uses REFRESH_DIV=4):
- Reset, then run 8 cycles → an_sel=1110 and seg=1000000 during cycles 0-3. Cycles 4-7: an_sel=1101, seg=1111111. busy=0, overflow=0.
- value=1234 pulsed → busy high for exactly 14 cycles. After the next 3→0 edge, one frame shows:
  - an_sel 1110 / seg 0011001
  - 1101 / 0110000
  - 1011 / 0100100
  - 0111 / 1111001
- value=7 → digits 3..1 show seg=1111111; digit 0 shows 1111000. With BLANK_LZ=0, digits 3..1 show 1000000.
- value=10000 → busy never rises. From the next frame, all digits show 0111111 and overflow=1. Then value=42 → overflow drops at the following frame; digits 1,0 show 0011001 and 0100100.
- value=1234, then value=5678 two cycles later (busy=1) → the second strobe is dropped and the display shows 1234.
- rst asserted during SHIFT cycle 7 → next cycle busy=0, an_sel=1110, seg=1000000. No stale value is ever committed afterwards.
